pipe_stage_slice: RTL and testbench
===================================

// Module: pipe_stage_slice
// PURPOSE
//  Parametrised pipeline-register successor to the fixed inter-stage latches (IF/ID ... MEM/WB).
//  Carries a control bundle and a data bundle across DEPTH register slices.
//  Adds a valid/ready handshake with full-throughput skid buffering, flush (bubble insertion)
//  and guaranteed zeroed control on bubbles.
//  Sits between any two MIPS pipeline stages; back-pressure replaces ad-hoc hazard stalls.
// PARAMETERS
//  CTRL_W  4   width of control bundle (MemWrite/MemRead/MemtoReg/RegWrite ...), >=1
//  DATA_W  69  width of data bundle (ALUresult, ReadData2, WriteRegister ...), >=1
//  DEPTH   1   number of cascaded slices (pipeline latency in cycles), 1..8
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       discard all in-flight entries (branch taken / exception)
//  in_valid   in   1       upstream stage presents an entry
//  in_ready   out  1       slice can accept; transfer when in_valid & in_ready
//  in_ctrl    in   CTRL_W  control bundle from upstream stage
//  in_data    in   DATA_W  data bundle from upstream stage
//  out_valid  out  1       entry available to downstream stage
//  out_ready  in   1       downstream accepts; transfer when out_valid & out_ready
//  out_ctrl   out  CTRL_W  control bundle; forced 0 whenever out_valid=0
//  out_data   out  DATA_W  data bundle
// BEHAVIOUR
//  - Reset (sync, priority over all): every slice EMPTY; out_valid=0, out_ctrl=0, out_data=0,
//    skid regs=0. in_ready=0 while reset is high; 1 on the first cycle after reset deasserts.
//  - Each slice holds a main reg and a skid reg; 3 states, encoded 2'b00/01/10:
//    EMPTY: main and skid invalid. Input accept -> BUSY (main <= in).
//    BUSY:  main valid. Accept & !drain -> FULL (skid <= in). Drain & !accept -> EMPTY.
//           Accept & drain -> BUSY (main <= in). Neither -> hold.
//    FULL:  main+skid valid; slice_in_ready=0. Drain -> BUSY (main <= skid). Else hold.
//  - slice_in_ready is a register (= state != FULL, next-state based); no combinational
//    path from out_ready to in_ready across any slice.
//  - Throughput: 1 entry/cycle with out_ready=1 held. Latency: accept at edge N ->
//    out_valid at edge N+DEPTH.
//  - Stall: out_ready=0 holds out_* stable (no change of ctrl/data while out_valid=1 &
//    !out_ready). Up to 2*DEPTH entries absorbed before in_ready drops.
//  - Ordering: strict FIFO; no entry lost or duplicated under any valid/ready pattern.
//  - Bubble: a slice whose main reg is invalid presents ctrl=0 (data value don't-care but
//    retains last value). Ensures no spurious RegWrite/MemWrite downstream.
//  - Flush: on the edge where flush=1 all slices -> EMPTY, out_ctrl=0, out_valid=0.
//    An input offered that cycle is dropped, even if in_ready=1. in_ready=1 the next cycle.
//    An output handshake in the flush cycle completes: downstream already sampled it.
//  - Simultaneous reset & flush: reset behaviour. flush & stall: flush wins.
//  - Widths: no arithmetic; bundles passed bit-exact, no truncation or extension.
// STRUCTURE
//  - Shared header pipe_defs.vh: slice state localparams (S_EMPTY, S_BUSY, S_FULL) and
//    CTRL bit index constants for the MIPS control bundle.
//  - One sub-module pipe_skid_slice (single 2-entry slice with the FSM above).
//  - Top: generate loop chaining DEPTH instances; flush/reset fanned out to all.
// TESTING
//  1. Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0,
//     in_ready=0; in_ready=1 the cycle after release.
//  2. Streaming DEPTH=3: send 0x01..0x10 back-to-back with out_ready=1 -> each appears
//     3 cycles later, 1 per cycle, in order, in_ready never drops.
//  3. Back-pressure DEPTH=2: out_ready=0 and stream 0xA0.. -> exactly 4 accepted, then
//     in_ready=0. Raise out_ready -> 0xA0..0xA3 emerge in order, out_* stable while stalled.
//  4. Flush: 3 entries in flight, ctrl=4'hF, pulse flush with in_valid=1 (0xBB) -> next
//     cycle out_valid=0, out_ctrl=0. 0xBB never appears. Next sent 0xCC emerges DEPTH later.
//  5. Random valid/ready (10k cycles, 50% each, DEPTH=1..4) -> scoreboard: FIFO order, no
//     loss or duplication, out_ctrl=0 whenever out_valid=0.
//  6. Reset mid-stall in FULL state -> next cycle all empty, outputs 0, prior entries never
//     emitted.

Source files
------------

// File: rtl/pipe_stage_slice_pkg.sv
// Shared definitions for the pipeline register slice: per-slice state
// encoding, MIPS control bundle bit positions and a small state helper.
package pipe_stage_slice_pkg;

    // Per-slice occupancy: main register only, or main plus skid register.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_BUSY  = 2'b01,
        S_FULL  = 2'b10
    } slice_state_e;

    // Bit positions of the MIPS control bundle carried in the ctrl field.
    localparam int CTRL_MEM_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_TO_REG = 2;
    localparam int CTRL_REG_WRITE  = 3;

    // A slice can take a new entry unless both of its registers are occupied.
    function automatic logic slice_can_accept(input slice_state_e st);
        return (st != S_FULL);
    endfunction

endpackage

// File: rtl/pipe_stage_slice_skid.sv
// One 2-entry register slice (main + skid) with a valid/ready handshake.
// in_ready is registered from the next state so the ready chain never
// forms a combinational path back from out_ready.
module pipe_stage_slice_skid
    import pipe_stage_slice_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 69
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    slice_state_e      state_q,     state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q,  in_ready_d;
    logic              accept_s;
    logic              drain_s;

    // Next-state and register updates; bubbles always carry a zeroed ctrl.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        accept_s    = in_valid & in_ready_q;
        drain_s     = out_valid_q & out_ready;

        if (flush) begin
            // Drop everything in flight, including any entry offered now.
            state_d     = S_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept_s) begin
                        state_d     = S_BUSY;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
                S_BUSY: begin
                    if (accept_s && !drain_s) begin
                        state_d     = S_FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (accept_s && drain_s) begin
                        state_d     = S_BUSY;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (drain_s) begin
                        state_d     = S_EMPTY;
                        main_ctrl_d = '0;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
                S_FULL: begin
                    if (drain_s) begin
                        state_d     = S_BUSY;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end else begin
                        state_d = S_FULL;
                    end
                end
                default: begin
                    state_d     = S_EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end

        out_valid_d = (state_d != S_EMPTY);
        in_ready_d  = slice_can_accept(state_d);
    end

    // State and payload registers; reset clears everything and holds in_ready low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/pipe_stage_slice.sv
// Parametrised inter-stage pipeline register: DEPTH skid slices chained
// back to back, carrying a control and a data bundle bit-exact.
// reset and flush reach every slice in the same cycle.
module pipe_stage_slice
    import pipe_stage_slice_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 69,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    // Index k is the input side of slice k; index DEPTH is the block output.
    logic [DEPTH:0]    valid_s;
    logic [DEPTH:0]    ready_s;
    logic [CTRL_W-1:0] ctrl_s [DEPTH+1];
    logic [DATA_W-1:0] data_s [DEPTH+1];

    assign valid_s[0]     = in_valid;
    assign ctrl_s[0]      = in_ctrl;
    assign data_s[0]      = in_data;
    assign in_ready       = ready_s[0];
    assign ready_s[DEPTH] = out_ready;
    assign out_valid      = valid_s[DEPTH];
    assign out_ctrl       = ctrl_s[DEPTH];
    assign out_data       = data_s[DEPTH];

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_slice
            pipe_stage_slice_skid #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_slice (
                .clk       (clk),
                .reset     (reset),
                .flush     (flush),
                .in_valid  (valid_s[k]),
                .in_ready  (ready_s[k]),
                .in_ctrl   (ctrl_s[k]),
                .in_data   (data_s[k]),
                .out_valid (valid_s[k+1]),
                .out_ready (ready_s[k+1]),
                .out_ctrl  (ctrl_s[k+1]),
                .out_data  (data_s[k+1])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_slice.sv
// Self-checking bench: four instances (DEPTH 1..4) share stimulus; the
// selected one is checked against a FIFO reference model (queue of
// accepted entries, cleared on flush/reset).
module tb_pipe_stage_slice;

    localparam int CW = 4;
    localparam int DW = 69;
    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          ir [NI];
    logic          ov [NI];
    logic [CW-1:0] oc [NI];
    logic [DW-1:0] od [NI];

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            pipe_stage_slice #(
                .CTRL_W (CW),
                .DATA_W (DW),
                .DEPTH  (g + 1)
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .flush     (flush),
                .in_valid  (in_valid),
                .in_ready  (ir[g]),
                .in_ctrl   (in_ctrl),
                .in_data   (in_data),
                .out_valid (ov[g]),
                .out_ready (out_ready),
                .out_ctrl  (oc[g]),
                .out_data  (od[g])
            );
        end
    endgenerate

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int cyc   = 0;
    int n_acc = 0;

    logic [CW+DW-1:0] exp_q [$];
    int               cyc_q [$];
    bit               chk_lat     = 1'b0;
    bit               prev_stall  = 1'b0;
    bit               after_rst   = 1'b0;
    bit               after_flush = 1'b0;
    logic [CW+DW-1:0] prev_out    = '0;

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (depth=%0d cyc=%0d)", tag, got, exp, sel + 1, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model, wait a negedge.
    task automatic cycle(input bit rst, input bit fl, input bit iv,
                         input logic [CW-1:0] c, input logic [DW-1:0] d, input bit ordy);
        logic             v;
        logic             r;
        logic [CW+DW-1:0] o;
        logic [CW+DW-1:0] e;
        int               t;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        v = ov[sel];
        r = ir[sel];
        o = {oc[sel], od[sel]};

        if (!v) chk_eq("bubble_ctrl", 128'(oc[sel]), 128'(0));
        if (after_rst) begin
            chk_eq("rst_valid", 128'(v), 128'(0));
            chk_eq("rst_out", 128'(o), 128'(0));
            chk_eq("rst_ready", 128'(r), 128'(0));
        end
        if (after_flush) begin
            chk_eq("flush_valid", 128'(v), 128'(0));
            chk_eq("flush_ready", 128'(r), 128'(1));
        end
        if (prev_stall) chk_eq("stall_hold", 128'({v, o}), 128'({1'b1, prev_out}));

        if (rst) begin
            exp_q.delete();
            cyc_q.delete();
        end else begin
            if (v && ordy) begin
                chk_eq("spurious", 128'(exp_q.size() == 0), 128'(0));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    t = cyc_q.pop_front();
                    chk_eq("order", 128'(o), 128'(e));
                    if (chk_lat) chk_eq("latency", 128'(cyc - t), 128'(sel + 1));
                end
            end
            if (fl) begin
                exp_q.delete();
                cyc_q.delete();
            end else if (iv && r) begin
                exp_q.push_back({c, d});
                cyc_q.push_back(cyc);
                n_acc++;
            end
        end

        prev_stall  = !rst && !fl && v && !ordy;
        prev_out    = o;
        after_rst   = rst;
        after_flush = fl && !rst;
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b1, 4'hF, 69'h1_2345_6789, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 4'hF, 69'h1_2345_6789, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 69'h0, 1'b1);
        chk_eq("ready_after_rst", 128'(ir[sel]), 128'(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 4'h0, 69'h0, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] val;
        logic [31:0]   tag;
        bit            fl;
        bit            iv;
        bit            ordy;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'hF;
        in_data   = 69'h0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // 1. Reset with in_valid held high.
        sel = 2;
        do_reset();

        // 2. Streaming through DEPTH=3.
        sel = 2;
        do_reset();
        chk_lat = 1'b1;
        n_acc   = 0;
        for (int i = 1; i <= 16; i++) begin
            chk_eq("stream_ready", 128'(ir[sel]), 128'(1));
            cycle(1'b0, 1'b0, 1'b1, 4'(i), 69'(i), 1'b1);
        end
        idle(8);
        chk_eq("stream_accepts", 128'(n_acc), 128'(16));
        chk_eq("stream_drained", 128'(exp_q.size()), 128'(0));
        chk_lat = 1'b0;

        // 3. Back-pressure on DEPTH=2: exactly 2*DEPTH entries absorbed.
        sel = 1;
        do_reset();
        n_acc = 0;
        val   = 69'hA0;
        for (int i = 0; i < 8; i++) begin
            iv = ir[sel];
            cycle(1'b0, 1'b0, 1'b1, 4'h5, val, 1'b0);
            if (iv) val = val + 69'd1;
        end
        chk_eq("bp_accepts", 128'(n_acc), 128'(4));
        chk_eq("bp_ready_low", 128'(ir[sel]), 128'(0));
        idle(8);
        chk_eq("bp_drained", 128'(exp_q.size()), 128'(0));

        // 4. Flush with entries in flight on DEPTH=3; 0xBB must be dropped.
        sel = 2;
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 4'hF, 69'(i + 1), 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 4'hF, 69'hBB, 1'b1);
        idle(6);
        chk_lat = 1'b1;
        n_acc   = 0;
        cycle(1'b0, 1'b0, 1'b1, 4'h9, 69'hCC, 1'b1);
        idle(5);
        chk_eq("flush_cc_sent", 128'(n_acc), 128'(1));
        chk_eq("flush_drained", 128'(exp_q.size()), 128'(0));
        chk_lat = 1'b0;

        // 5. Random valid/ready with occasional flush, every depth.
        tag = 32'd0;
        for (int s = 0; s < NI; s++) begin
            sel = s;
            do_reset();
            for (int i = 0; i < 2500; i++) begin
                fl   = ($urandom_range(0, 63) == 0);
                iv   = 1'($urandom_range(0, 1));
                ordy = 1'($urandom_range(0, 1));
                cycle(1'b0, fl, iv, 4'($urandom()), {37'($urandom()), tag}, ordy);
                tag = tag + 32'd1;
            end
            idle(20);
            chk_eq("rand_drained", 128'(exp_q.size()), 128'(0));
        end

        // 6. Reset while stalled with every slice FULL (DEPTH=2).
        sel = 1;
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 4'hE, 69'(32'hD0 + i), 1'b0);
        chk_eq("full_before_rst", 128'(ir[sel]), 128'(0));
        cycle(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b0);
        idle(10);
        chk_eq("rst_stall_empty", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
